mem_access_unit: RTL

- Load/store front end directly upstream of the data RAM.
- Accepts one load or store request at a time from the MEM pipeline stage.
- Drives the RAM's enable, byte-write-enable, word address and write data, and absorbs the RAM's one-cycle read latency.
- Returns sign/zero-extended load data, or a store acknowledge, through a valid/ready response port.

---
 rtl/mem_access_unit_pkg.sv | 58 +++++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and lane helpers for the load/store front end.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_LANES      = MEM_DATA_WIDTH / 8;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_RESP      = 2'd2
    } mem_state_t;

    // Load context carried from the accept cycle to the RAM data cycle.
    typedef struct packed {
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] offset;
    } load_meta_t;

    function automatic logic [MEM_LANES-1:0] mem_byte_en(input logic [1:0] size,
                                                         input logic [1:0] offset);
        logic [MEM_LANES-1:0] be;
        case (size)
            MEM_SIZE_BYTE: be = 4'b0001 << offset;
            MEM_SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [MEM_DATA_WIDTH-1:0] mem_lane_data(input logic [1:0] size,
                                                                input logic [MEM_DATA_WIDTH-1:0] wdata);
        logic [MEM_DATA_WIDTH-1:0] d;
        case (size)
            MEM_SIZE_BYTE: d = {4{wdata[7:0]}};
            MEM_SIZE_HALF: d = {2{wdata[15:0]}};
            default:       d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic m;
        case (size)
            MEM_SIZE_BYTE: m = 1'b0;
            MEM_SIZE_HALF: m = offset[0];
            default:       m = (offset != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed lane(s) of a raw RAM word and sign/zero-extends them.
// Latency: combinational.
// Backpressure: none; pure datapath.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [MEM_DATA_WIDTH-1:0] raw_word,
    input  logic [1:0]                size,
    input  logic                      is_unsigned,
    input  logic [1:0]                offset,
    output logic [MEM_DATA_WIDTH-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = raw_word[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? raw_word[31:16] : raw_word[15:0];
        load_data = raw_word;
        case (size)
            MEM_SIZE_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_SIZE_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:       load_data = raw_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the data RAM; optional MEM_ACCESS_ALIGN_CHECK_EN traps misaligned accesses.
// Latency: store response 1 cycle after accept, load 2 cycles (RAM read latency absorbed in READ_WAIT).
// Backpressure: one request in flight; req_ready drops while a response waits for resp_ready.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_exc,
    output logic [ADDR_WIDTH-1:0] resp_badvaddr,
    output logic                  ram_en,
    output logic [3:0]            ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    mem_state_t                state;
    load_meta_t                meta;
    logic                      accept;
    logic                      mis;
    logic [DATA_WIDTH-1:0]     load_data;

    assign req_ready = !rst && (state == ST_IDLE || (state == ST_RESP && resp_ready));
    assign accept    = req_valid && req_ready;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic                  exc_q;
    logic [ADDR_WIDTH-1:0] badvaddr_q;

    assign mis           = mem_misaligned(req_size, req_addr[1:0]);
    assign resp_exc      = exc_q;
    assign resp_badvaddr = badvaddr_q;
`else
    assign mis           = 1'b0;
    assign resp_exc      = 1'b0;
    assign resp_badvaddr = '0;
`endif

    // RAM port is driven only during the accept cycle so the RAM sees exactly one access per request.
    always_comb begin
        ram_en         = 1'b0;
        ram_write_en   = 4'b0000;
        ram_addr       = '0;
        ram_write_data = '0;
        if (accept && !mis) begin
            ram_en   = 1'b1;
            ram_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_we) begin
                ram_write_en   = mem_byte_en(req_size, req_addr[1:0]);
                ram_write_data = mem_lane_data(req_size, req_wdata);
            end
        end
    end

    mem_load_align u_load_align (
        .raw_word    (ram_read_data),
        .size        (meta.size),
        .is_unsigned (meta.is_unsigned),
        .offset      (meta.offset),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            meta       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            exc_q      <= 1'b0;
            badvaddr_q <= '0;
`endif
        end else if (accept) begin
            meta       <= '{size: req_size, is_unsigned: req_unsigned, offset: req_addr[1:0]};
            resp_rdata <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            exc_q      <= mis;
            badvaddr_q <= mis ? req_addr : '0;
`endif
            if (mis || req_we) begin
                state      <= ST_RESP;
                resp_valid <= 1'b1;
            end else begin
                state      <= ST_READ_WAIT;
                resp_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_READ_WAIT: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        exc_q      <= 1'b0;
                        badvaddr_q <= '0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
